polyshift_l_seq: RTL and testbench
==================================

# polyshift_l_seq

Multi-cycle left-direction counterpart of the combinational right shifter. It shifts a `word_width`-bit word left by 0..`word_width`-1 positions in one of four modes, selected by the shared `SHIFT_TYPE` encoding:

- logical
- arithmetic
- through-carry, with double-precision fill from `C_IN`
- rotate

It applies one barrel stage per clock behind a valid/ready handshake on both sides. It sits in the datapath next to `polyshift_r`, for area-constrained configurations where a single-cycle left barrel shifter is too costly.

## Interface
- `word_width`, 8, data width; must be a power of two and at least 4.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `D_IN`  in  `word_width`  operand.
- `C_IN`  in  `word_width`-1  double-precision fill source, used in mode 2 only.
- `shift_size`  in  `$clog2(word_width)`  shift amount.
- `shift_type`  in  `SHIFT_TYPE` (2)  mode: LOGIC=0, ARITH=1, 2 = through-carry (RCL), 3 = rotate (ROL).
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  block can accept an operand.
- `D_OUT`  out  `word_width`  registered result.
- `out_valid`  out  1  `D_OUT` holds a result.
- `out_ready`  in  1  consumer takes the result.

## Operation
- Internal working register `acc`, 2·`word_width`-1 bits. `D_OUT` is the top `word_width` bits of `acc`.
- Load value of `acc` on accept, by mode:
  - LOGIC and ARITH: {`D_IN`, zeros}. ARITH left equals LOGIC (SAL); no overflow flag.
  - Mode 2: {`D_IN`, `C_IN`}. Result = top `word_width` bits of ({D,C} << size).
  - Mode 3: {`D_IN`, `D_IN`[`word_width`-1:1]}. Result = top `word_width` bits of ({D,D} << size).
- Shift rule: stage k shifts `acc` left by 2^k when the latched `shift_size`[k] is 1. Zero fill enters at the LSB of `acc`; it never reaches `D_OUT` for size ≤ `word_width`-1.
- `shift_size` and `shift_type` are latched on accept. Later input changes have no effect on an operation in flight.
- FSM states:
  - IDLE: `in_ready`=1. When `in_valid`=1, load `acc`, clear stage counter `stg`, and go to SHIFT.
  - SHIFT: apply stage `stg`, then increment it. After stage L-1 (L = `$clog2(word_width)`), go to DONE.
  - DONE: `out_valid`=1. When `out_ready`=1, go to IDLE.
- `in_ready` is high only in IDLE; input and output phases never overlap.
- `shift_size`=0 still passes through all L stages, so latency is fixed.

## Timing
- Accept on edge n (`in_valid` & `in_ready`). Stages are applied on edges n+1 through n+L. `out_valid` rises after edge n+L.
- `D_OUT` is stable for the whole time `out_valid` is high. The earliest next accept is edge n+L+2.
- The handshake completes on the edge where `out_valid` & `out_ready`. `out_valid` drops after that edge and `in_ready` rises in the same cycle.
- `out_ready` held low: remain in DONE indefinitely and keep `D_OUT` unchanged.
- `out_ready` high before DONE: ignored.
- `in_valid` outside IDLE: ignored; no operand is captured.
- Reset values, applied immediately on `RST_N` low regardless of clock:
  - state = IDLE, `acc` = 0, `stg` = 0
  - `D_OUT` = 0, `out_valid` = 0
  - `in_ready` = 0 while `RST_N` is low, and 1 from the first cycle after release.
- Reset mid-SHIFT or in DONE: the operation is discarded and no result is ever presented.

## Structure
- The shared package (existing one that holds `SHIFT_TYPE`) gains a state enum `POLYSHIFT_SEQ_STATE` {IDLE, SHIFT, DONE}.
- Sub-module `polyshift_l_stage` #(`word_width`, stage index k): combinational. Inputs: `acc`, enable bit. Output: `acc` << 2^k with zero fill. The top level instantiates one per stage and muxes by `stg`, or keeps a single variable-index instance; either choice is acceptable if timing holds.
- Top level: FSM, `stg` counter, load mux by `shift_type`, handshake logic.

## Test plan
All scenarios use `word_width`=8 (L=3).
- **LOGIC:** `D_IN`=8'b1001_0110, size 3 → `D_OUT`=8'b1011_0000. ARITH with the same operands gives the same result. `out_valid` rises exactly 3 cycles after the accept edge.
- **Mode 2 / mode 3:**
  - Mode 2: `D_IN`=8'b1001_0110, `C_IN`=7'b101_0101, size 3 → 8'b1011_0101.
  - Mode 3: same `D_IN`, size 3 → 8'b1011_0100.
  - Size 7 in mode 3 → 8'b0100_1011.
- **Exhaustive sweep:** all 4 modes × sizes 0..7 × random `D_IN`/`C_IN`, compared against the {D,C} / {D,D} reference formulas. Size 0 must return `D_IN` unchanged.
- **Backpressure:**
  - Hold `out_ready`=0 for 10 cycles → `out_valid` stays 1, `D_OUT` stays constant, `in_ready` stays 0.
  - Toggle `D_IN` and `shift_size` during this window → no effect on the held result.
- **Back-to-back:** continuous `in_valid` with `out_ready`=1 → one result every 5 cycles (L+2), in order, with no lost or duplicated operands.
- **Reset:** assert `RST_N` low mid-SHIFT (after stage 1) → `out_valid`=0 and `D_OUT`=0 immediately. After release, `in_ready`=1, and a fresh operation completes correctly.

Source files
------------

// File: rtl/polyshift_l_seq_pkg.sv
// polyshift_l_seq_pkg: shared shift-mode encoding and sequential shifter state enum
package polyshift_l_seq_pkg;
    typedef enum logic [1:0] {LOGIC = 2'd0, ARITH = 2'd1, RCL = 2'd2, ROL = 2'd3} SHIFT_TYPE;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} POLYSHIFT_SEQ_STATE;
endpackage

// File: rtl/polyshift_l_stage.sv
// polyshift_l_stage: one barrel stage, shifts the working register left by 2^k when enabled
module polyshift_l_stage
    import polyshift_l_seq_pkg::*;
#(
    parameter int word_width = 8,
    parameter int k = 0
) (
    input  logic [2*word_width-2:0] acc,
    input  logic                    en,
    output logic [2*word_width-2:0] acc_shl
);
    assign acc_shl = en ? acc << (2**k) : acc;
endmodule

// File: rtl/polyshift_l_seq.sv
// polyshift_l_seq: multi-cycle left shifter (logic/arith/through-carry/rotate), one barrel stage per clock
module polyshift_l_seq
    import polyshift_l_seq_pkg::*;
#(
    parameter int word_width = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [word_width-1:0]         D_IN,
    input  logic [word_width-2:0]         C_IN,
    input  logic [$clog2(word_width)-1:0] shift_size,
    input  logic [1:0]                    shift_type,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [word_width-1:0]         D_OUT,
    output logic                          out_valid,
    input  logic                          out_ready
);
    localparam int L  = $clog2(word_width);
    localparam int AW = 2*word_width-1;
    localparam int SW = $clog2(L);

    POLYSHIFT_SEQ_STATE state, nxt;
    logic [AW-1:0] acc, ld;
    logic [SW-1:0] stg;
    logic [L-1:0]  sz;
    logic [AW-1:0] stage_out [L];

    for (genvar i = 0; i < L; i++) begin : g_stage
        polyshift_l_stage #(.word_width(word_width), .k(i)) u_stage (
            .acc     (acc),
            .en      (sz[i]),
            .acc_shl (stage_out[i])
        );
    end

    // Low half of acc supplies the bits that enter D_OUT from the right
    always_comb begin
        ld = (shift_type == RCL) ? {D_IN, C_IN} :
             (shift_type == ROL) ? {D_IN, D_IN[word_width-1:1]} :
                                   {D_IN, {(word_width-1){1'b0}}};
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = in_valid ? SHIFT : IDLE;
            SHIFT:   nxt = (stg == SW'(L-1)) ? DONE : SHIFT;
            DONE:    nxt = out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            acc   <= '0;
            stg   <= '0;
            sz    <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && in_valid) begin
                acc <= ld;
                stg <= '0;
                sz  <= shift_size;
            end else if (state == SHIFT) begin
                acc <= stage_out[stg];
                stg <= stg + 1'b1;
            end
        end
    end

    assign in_ready  = (state == IDLE) && RST_N;
    assign out_valid = (state == DONE);
    assign D_OUT     = acc[AW-1 -: word_width];
endmodule

// File: tb/tb_polyshift_l_seq.sv
// tb_polyshift_l_seq: directed self-checking bench for the sequential left shifter
module tb_polyshift_l_seq;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] D_IN;
    logic [6:0] C_IN;
    logic [2:0] shift_size;
    logic [1:0] shift_type;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] D_OUT;
    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    polyshift_l_seq #(.word_width(8)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .D_IN       (D_IN),
        .C_IN       (C_IN),
        .shift_size (shift_size),
        .shift_type (shift_type),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .D_OUT      (D_OUT),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Reference: top 8 bits of the 15-bit concatenation shifted left
    function automatic logic [7:0] ref_fn(input logic [7:0] d, input logic [6:0] c,
                                          input logic [2:0] s, input logic [1:0] t);
        logic [14:0] v;
        v = (t == 2'd2) ? {d, c} : (t == 2'd3) ? {d, d[7:1]} : {d, 7'd0};
        v = v << s;
        return v[14:7];
    endfunction

    // Runs one operation; lat = cycles from accept edge to out_valid, -1 on timeout
    task automatic run_op(input logic [7:0] d, input logic [6:0] c, input logic [2:0] s,
                          input logic [1:0] t, output logic [7:0] res, output int lat);
        int w;
        @(negedge CLK);
        D_IN = d; C_IN = c; shift_size = s; shift_type = t; in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 20) begin @(negedge CLK); w++; end
        if (!in_ready) begin
            in_valid = 1'b0; res = 8'hxx; lat = -1;
            return;
        end
        @(posedge CLK);
        lat = 0;
        @(negedge CLK);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin lat++; @(negedge CLK); end
        if (!out_valid) lat = -1;
        res = D_OUT;
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        D_IN = '0; C_IN = '0; shift_size = '0; shift_type = '0;
        repeat (2) @(negedge CLK);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (D_OUT !== 8'h00) begin failures++; $display("FAIL reset_d_out got=%h exp=00", D_OUT); end
        RST_N = 1'b1;
        @(negedge CLK);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_logic();
        logic [7:0] r;
        int lat;
        run_op(8'b1001_0110, 7'h7F, 3'd3, 2'd0, r, lat);
        checks++; if (r !== 8'b1011_0000) begin failures++; $display("FAIL logic_result got=%b exp=10110000", r); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL logic_latency got=%0d exp=3", lat); end
        run_op(8'b1001_0110, 7'h7F, 3'd3, 2'd1, r, lat);
        checks++; if (r !== 8'b1011_0000) begin failures++; $display("FAIL arith_result got=%b exp=10110000", r); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL arith_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_modes();
        logic [7:0] r;
        int lat;
        run_op(8'b1001_0110, 7'b101_0101, 3'd3, 2'd2, r, lat);
        checks++; if (r !== 8'b1011_0101) begin failures++; $display("FAIL rcl_s3 got=%b exp=10110101", r); end
        run_op(8'b1001_0110, 7'b000_0000, 3'd3, 2'd3, r, lat);
        checks++; if (r !== 8'b1011_0100) begin failures++; $display("FAIL rol_s3 got=%b exp=10110100", r); end
        run_op(8'b1001_0110, 7'b111_1111, 3'd7, 2'd3, r, lat);
        checks++; if (r !== 8'b0100_1011) begin failures++; $display("FAIL rol_s7 got=%b exp=01001011", r); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL rol_s7_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_sweep();
        logic [7:0] r, d, e;
        logic [6:0] c;
        int lat;
        for (int t = 0; t < 4; t++) begin
            for (int s = 0; s < 8; s++) begin
                d = 8'($urandom);
                c = 7'($urandom);
                e = ref_fn(d, c, 3'(s), 2'(t));
                run_op(d, c, 3'(s), 2'(t), r, lat);
                checks++;
                if (r !== e) begin
                    failures++;
                    $display("FAIL sweep mode=%0d size=%0d d=%h c=%h got=%h exp=%h", t, s, d, c, r, e);
                end
                if (s == 0) begin
                    checks++;
                    if (r !== d) begin failures++; $display("FAIL sweep_size0 mode=%0d got=%h exp=%h", t, r, d); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int w;
        int bad;
        @(negedge CLK);
        D_IN = 8'h3C; C_IN = 7'h11; shift_size = 3'd5; shift_type = 2'd3; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin @(negedge CLK); w++; end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout out_valid=%b exp=1", out_valid); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || D_OUT !== 8'h87 || in_ready !== 1'b0) begin
                failures++; bad++;
                $display("FAIL bp_hold cycle=%0d out_valid=%b d_out=%h in_ready=%b exp=1/87/0", i, out_valid, D_OUT, in_ready);
            end
            D_IN = ~D_IN; shift_size = shift_size + 3'd1; in_valid = i[0];
            @(negedge CLK);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ds [4] = '{8'h81, 8'h5A, 8'hF0, 8'h0F};
        logic [2:0] ss [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [7:0] es [4] = '{8'h03, 8'h69, 8'h87, 8'hF0};
        int acnt, rcnt, last;
        acnt = 0; rcnt = 0; last = -1;
        out_ready = 1'b1; shift_type = 2'd3; C_IN = 7'h00;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge CLK);
            if (out_valid) begin
                checks++;
                if (rcnt >= 4 || D_OUT !== es[rcnt & 3]) begin
                    failures++;
                    $display("FAIL b2b_result idx=%0d got=%h exp=%h", rcnt, D_OUT, es[rcnt & 3]);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 5) begin failures++; $display("FAIL b2b_spacing got=%0d exp=5", cyc - last); end
                end
                last = cyc;
                rcnt++;
            end
            if (in_ready) begin
                if (acnt < 4) begin
                    D_IN = ds[acnt]; shift_size = ss[acnt]; in_valid = 1'b1; acnt++;
                end else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (rcnt != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", rcnt); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] r;
        int lat, bad;
        @(negedge CLK);
        D_IN = 8'hA5; C_IN = 7'h00; shift_size = 3'd0; shift_type = 2'd0; in_valid = 1'b1; out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mr_pre_in_ready got=%b exp=1", in_ready); end
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mr_out_valid got=%b exp=0", out_valid); end
        checks++; if (D_OUT !== 8'h00) begin failures++; $display("FAIL mr_d_out got=%h exp=00", D_OUT); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mr_in_ready got=%b exp=0", in_ready); end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mr_release_in_ready got=%b exp=1", in_ready); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0) bad++;
            @(negedge CLK);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL mr_stale_result cycles=%0d exp=0", bad); end
        run_op(8'b1001_0110, 7'b101_0101, 3'd3, 2'd2, r, lat);
        checks++; if (r !== 8'b1011_0101) begin failures++; $display("FAIL mr_fresh_op got=%b exp=10110101", r); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL mr_fresh_latency got=%0d exp=3", lat); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_logic();
        test_modes();
        test_sweep();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
